// File: rtl/video_mode_ctrl.sv
// Layer-select controller for the pixel compositor: debounced buttons or direct switches
// build a pending selection that is committed to the outputs only at frame start.
module video_mode_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [1:0] BG_RESET        = 2'b00,
    parameter logic [1:0] TARGET_RESET    = 2'b00,
    parameter int         ALLOW_TEST      = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_bg_in,
    input  logic       btn_target_in,
    input  logic       direct_en_in,
    input  logic [3:0] sw_direct_in,
    input  logic       new_frame_in,
    output logic [1:0] bg_out,
    output logic [1:0] target_out,
    output logic       pending_out,
    output logic       mode_changed_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the background button, bit 1 the overlay button.
    logic [1:0]            sync_a;
    logic [1:0]            sync_b;
    logic [1:0]            db_level;
    logic [1:0]            press;
    logic [1:0][CNT_W-1:0] db_cnt;

    logic [1:0] pending_bg;
    logic [1:0] pending_tgt;

    function automatic logic [1:0] next_target(input logic [1:0] cur);
        if (ALLOW_TEST != 0)
            return cur + 2'd1;
        else
            return (cur >= 2'd2) ? 2'd0 : cur + 2'd1;
    endfunction

    // Press is registered on the edge the debounced level rises, so it is
    // consumed by the pending registers exactly one cycle later.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_level <= '0;
            press    <= '0;
            db_cnt   <= '0;
        end else begin
            sync_a <= {btn_target_in, btn_bg_in};
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_b[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db_level[i] <= ~db_level[i];
                    db_cnt[i]   <= '0;
                    press[i]    <= ~db_level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Commit samples the pending values before this cycle's press lands, so a
    // press coinciding with a frame pulse waits for the next frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_bg       <= BG_RESET;
            pending_tgt      <= TARGET_RESET;
            bg_out           <= BG_RESET;
            target_out       <= TARGET_RESET;
            mode_changed_out <= 1'b0;
        end else begin
            if (new_frame_in) begin
                bg_out           <= pending_bg;
                target_out       <= pending_tgt;
                mode_changed_out <= (pending_bg != bg_out) || (pending_tgt != target_out);
            end else begin
                mode_changed_out <= 1'b0;
            end

            if (direct_en_in) begin
                pending_bg  <= sw_direct_in[1:0];
                pending_tgt <= sw_direct_in[3:2];
            end else begin
                if (press[0])
                    pending_bg <= pending_bg + 2'd1;
                if (press[1])
                    pending_tgt <= next_target(pending_tgt);
            end
        end
    end

    assign pending_out = (pending_bg != bg_out) || (pending_tgt != target_out);

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomised and directed bench for video_mode_ctrl; two instances differ only in
// ALLOW_TEST and are both compared every cycle against a frame-level reference model.
module tb_video_mode_ctrl;

    localparam int         DEB    = 4;
    localparam logic [1:0] BG_R   = 2'd2;
    localparam logic [1:0] TGT_R  = 2'd1;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       btn_bg_in = 1'b0;
    logic       btn_target_in = 1'b0;
    logic       direct_en_in = 1'b0;
    logic [3:0] sw_direct_in = 4'd0;
    logic       new_frame_in = 1'b0;

    logic [1:0] bg_o   [2];
    logic [1:0] tgt_o  [2];
    logic       pend_o [2];
    logic       mc_o   [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: index 0 models ALLOW_TEST=0, index 1 models ALLOW_TEST=1.
    logic [1:0] m_bg [2];
    logic [1:0] m_tgt [2];
    logic [1:0] m_pbg [2];
    logic [1:0] m_ptgt [2];
    logic       m_mc [2];
    logic [1:0] lvl;
    logic [1:0] m_press;
    logic [1:0] raw_q [$];
    logic [1:0] samp_q [$];

    always #5 clk_in = ~clk_in;

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .BG_RESET(BG_R), .TARGET_RESET(TGT_R), .ALLOW_TEST(0)
    ) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .btn_bg_in(btn_bg_in), .btn_target_in(btn_target_in),
        .direct_en_in(direct_en_in), .sw_direct_in(sw_direct_in), .new_frame_in(new_frame_in),
        .bg_out(bg_o[0]), .target_out(tgt_o[0]), .pending_out(pend_o[0]),
        .mode_changed_out(mc_o[0])
    );

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .BG_RESET(BG_R), .TARGET_RESET(TGT_R), .ALLOW_TEST(1)
    ) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .btn_bg_in(btn_bg_in), .btn_target_in(btn_target_in),
        .direct_en_in(direct_en_in), .sw_direct_in(sw_direct_in), .new_frame_in(new_frame_in),
        .bg_out(bg_o[1]), .target_out(tgt_o[1]), .pending_out(pend_o[1]),
        .mode_changed_out(mc_o[1])
    );

    // A debounced level flips once the last DEB synchronised samples (raw delayed
    // by two edges) all disagree with it; a rising flip is a press used next edge.
    task automatic modelEdge();
        logic [1:0] s;
        logic [1:0] newp;
        logic       all_diff;
        if (rst_in) begin
            for (int k = 0; k < 2; k++) begin
                m_bg[k] = BG_R;  m_tgt[k] = TGT_R;
                m_pbg[k] = BG_R; m_ptgt[k] = TGT_R;
                m_mc[k] = 1'b0;
            end
            lvl = '0;
            m_press = '0;
            raw_q = {2'b00, 2'b00};
            samp_q = {};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (new_frame_in) begin
                    m_mc[k]  = (m_pbg[k] != m_bg[k]) || (m_ptgt[k] != m_tgt[k]);
                    m_bg[k]  = m_pbg[k];
                    m_tgt[k] = m_ptgt[k];
                end else begin
                    m_mc[k] = 1'b0;
                end
                if (direct_en_in) begin
                    m_pbg[k]  = sw_direct_in[1:0];
                    m_ptgt[k] = sw_direct_in[3:2];
                end else begin
                    if (m_press[0])
                        m_pbg[k] = 2'((m_pbg[k] + 1) % 4);
                    if (m_press[1]) begin
                        if (k == 1)
                            m_ptgt[k] = 2'((m_ptgt[k] + 1) % 4);
                        else
                            m_ptgt[k] = (m_ptgt[k] >= 2) ? 2'd0 : 2'(m_ptgt[k] + 1);
                    end
                end
            end
            raw_q.push_back({btn_target_in, btn_bg_in});
            s = raw_q[raw_q.size() - 3];
            if (raw_q.size() > 3)
                void'(raw_q.pop_front());
            samp_q.push_back(s);
            if (samp_q.size() > DEB)
                void'(samp_q.pop_front());
            newp = '0;
            for (int i = 0; i < 2; i++) begin
                if (samp_q.size() == DEB) begin
                    all_diff = 1'b1;
                    foreach (samp_q[j])
                        if (samp_q[j][i] == lvl[i])
                            all_diff = 1'b0;
                    if (all_diff) begin
                        lvl[i]  = ~lvl[i];
                        newp[i] = lvl[i];
                    end
                end
            end
            m_press = newp;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs set before the edge are taken by both DUT and model,
    // then every output of both instances is compared 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge clk_in);
        #1;
        modelEdge();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("bg_out/inst%0d", k), bg_o[k], m_bg[k]);
            checkOutput($sformatf("target_out/inst%0d", k), tgt_o[k], m_tgt[k]);
            checkOutput($sformatf("pending_out/inst%0d", k), {1'b0, pend_o[k]},
                        {1'b0, (m_pbg[k] != m_bg[k]) || (m_ptgt[k] != m_tgt[k])});
            checkOutput($sformatf("mode_changed_out/inst%0d", k), {1'b0, mc_o[k]}, {1'b0, m_mc[k]});
        end
    endtask

    task automatic holdButtons(input logic bg, input logic tg, input int cycles);
        btn_bg_in = bg;
        btn_target_in = tg;
        repeat (cycles) applyStimulus();
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        applyStimulus();
        new_frame_in = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int hold;
        repeat (2) applyStimulus();
        rst_in = 1'b0;
        repeat (2) applyStimulus();

        // Reset landing in the middle of a debounce leaves no press behind.
        holdButtons(1'b1, 1'b0, 3);
        rst_in = 1'b1;
        btn_bg_in = 1'b0;
        applyStimulus();
        rst_in = 1'b0;
        holdButtons(1'b0, 1'b0, 10);

        holdButtons(1'b1, 1'b0, 3);
        holdButtons(1'b0, 1'b0, 8);
        holdButtons(1'b1, 1'b0, 10);
        holdButtons(1'b0, 1'b0, 8);
        frame();

        repeat (4) begin
            holdButtons(1'b0, 1'b1, 6);
            holdButtons(1'b0, 1'b0, 6);
        end
        frame();

        // Press reaches pending exactly on the frame-pulse edge.
        btn_bg_in = 1'b1;
        repeat (6) applyStimulus();
        new_frame_in = 1'b1;
        applyStimulus();
        new_frame_in = 1'b0;
        holdButtons(1'b1, 1'b0, 4);
        holdButtons(1'b0, 1'b0, 8);
        frame();

        direct_en_in = 1'b1;
        sw_direct_in = 4'b1101;
        holdButtons(1'b1, 1'b0, 8);
        holdButtons(1'b0, 1'b0, 6);
        frame();
        direct_en_in = 1'b0;
        holdButtons(1'b0, 1'b1, 8);
        holdButtons(1'b0, 1'b0, 6);
        frame();

        repeat (3) begin
            frame();
            repeat (3) applyStimulus();
        end

        for (int n = 0; n < 120; n++) begin
            btn_bg_in = 1'($urandom_range(0, 1));
            btn_target_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                direct_en_in = ~direct_en_in;
            if ($urandom_range(0, 3) == 0)
                sw_direct_in = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 9));
            for (int h = 0; h < hold; h++) begin
                new_frame_in = ($urandom_range(0, 5) == 0);
                rst_in = ($urandom_range(0, 199) == 0);
                applyStimulus();
            end
        end
        rst_in = 1'b0;
        new_frame_in = 1'b0;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
